bcd_addsub_seq: RTL and testbench

BCD_ADDSUB_SEQ -- requirements
Module: bcd_addsub_seq

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_alu.sv | 53 +++++
 rtl/bcd_addsub_seq.sv | 145 ++++++++++++++
 tb/tb_bcd_addsub_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD/binary add-subtract unit.
package bcd_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the 4-bit flags output; bit 2 is always 0
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_CARRY   = 1;
  localparam int FLAG_INVALID = 3;

  // Result of one digit step: the result nibble and its carry/borrow out
  typedef struct packed {
    logic [3:0] nibble;
    logic       carry;
  } digit_res_t;

endpackage

// File: rtl/bcd_digit_alu.sv
// Single-digit add/subtract, decimal or plain binary nibble arithmetic.
// The carry field means carry-out for add and borrow-out for subtract.
module bcd_digit_alu
  import bcd_pkg::*;
(
  input  logic       [3:0] a_d,
  input  logic       [3:0] b_d,
  input  logic             c_in,
  input  logic             sub,
  input  logic             bcd,
  output digit_res_t       res
);

  logic [4:0] sum;
  logic [4:0] diff;

  // Five-bit raw sum and difference; diff[4] is the sign of a_d - b_d - c_in
  assign sum  = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c_in};
  assign diff = {1'b0, a_d} - {1'b0, b_d} - {4'b0000, c_in};

  // Decimal correction (+6 on add overflow, +10 on subtract underflow) or raw nibble
  always_comb begin
    res = '0;
    if (!sub) begin
      if (bcd) begin
        if (sum > 5'd9) begin
          res.nibble = sum[3:0] + 4'd6;
          res.carry  = 1'b1;
        end else begin
          res.nibble = sum[3:0];
          res.carry  = 1'b0;
        end
      end else begin
        res.nibble = sum[3:0];
        res.carry  = sum[4];
      end
    end else begin
      if (bcd) begin
        if (diff[4]) begin
          res.nibble = diff[3:0] + 4'd10;
          res.carry  = 1'b1;
        end else begin
          res.nibble = diff[3:0];
          res.carry  = 1'b0;
        end
      end else begin
        res.nibble = diff[3:0];
        res.carry  = diff[4];
      end
    end
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Sequential multi-digit BCD/binary adder-subtractor: one digit per clock,
// least-significant digit first, using a single shared digit ALU.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                add_sub,
  input  logic                bcd_mode,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] r,
  output logic [3:0]          flags
);

  localparam int W     = 4 * DIGITS;
  localparam int CW    = ($clog2(DIGITS + 1) < 1) ? 1 : $clog2(DIGITS + 1);
  // Digit mux has a slot for every counter value so the index never runs out of range
  localparam int NSLOT = 1 << CW;

  state_t          state_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            sub_reg;
  logic            bcd_reg;
  logic            carry_reg;
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    work_reg;

  logic [3:0]      a_slot [NSLOT];
  logic [3:0]      b_slot [NSLOT];
  logic [DIGITS-1:0] nib_bad;
  logic            invalid;
  digit_res_t      alu_res;
  logic [W-1:0]    work_next;
  logic            last_digit;

  genvar gi;

  // Split latched operands into addressable digit slots; unused slots read as 0
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < DIGITS) begin : g_live
        assign a_slot[gi] = a_reg[4*gi +: 4];
        assign b_slot[gi] = b_reg[4*gi +: 4];
      end else begin : g_pad
        assign a_slot[gi] = 4'd0;
        assign b_slot[gi] = 4'd0;
      end
    end
  endgenerate

  // Any latched nibble above 9 marks a decimal operation as invalid
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_bad
      assign nib_bad[gi] = (a_reg[4*gi +: 4] > 4'd9) || (b_reg[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign invalid = bcd_reg && (|nib_bad);

  bcd_digit_alu u_alu (
    .a_d  (a_slot[cnt_reg]),
    .b_d  (b_slot[cnt_reg]),
    .c_in (carry_reg),
    .sub  (sub_reg),
    .bcd  (bcd_reg),
    .res  (alu_res)
  );

  // Working result shifts right one digit per step; after DIGITS steps digit 0 sits at the bottom
  generate
    if (DIGITS == 1) begin : g_w1
      assign work_next = alu_res.nibble;
    end else begin : g_wn
      assign work_next = {alu_res.nibble, work_reg[W-1:4]};
    end
  endgenerate

  assign last_digit = (cnt_reg == CW'(DIGITS - 1));

  // Controller, operand latches, working register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      bcd_reg   <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      work_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      r         <= '0;
      flags     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= add_sub;
            bcd_reg   <= bcd_mode;
            carry_reg <= carry_in;
            cnt_reg   <= '0;
            work_reg  <= '0;
            busy      <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          work_reg  <= work_next;
          carry_reg <= alu_res.carry;
          if (last_digit) begin
            cnt_reg             <= '0;
            busy                <= 1'b0;
            done                <= 1'b1;
            r                   <= work_next;
            flags[FLAG_INVALID] <= invalid;
            flags[2]            <= 1'b0;
            flags[FLAG_CARRY]   <= alu_res.carry;
            flags[FLAG_ZERO]    <= (work_next == '0);
            state_reg           <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Self-checking bench for bcd_addsub_seq (DIGITS=4): directed cases plus
// randomized operations against an arithmetic reference model.
module tb_bcd_addsub_seq;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        add_sub;
  logic        bcd_mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [15:0] r;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] prev_r;
  logic [3:0]  prev_flags;

  always #5 clk = ~clk;

  bcd_addsub_seq #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .add_sub  (add_sub),
    .bcd_mode (bcd_mode),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .r        (r),
    .flags    (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd_to_int(input logic [15:0] v);
    int acc = 0;
    for (int i = 3; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] o = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      o[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return o;
  endfunction

  // Returns {flags, r}
  function automatic logic [19:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic sub, input logic bcd, input logic cin);
    logic        inv = 1'b0;
    logic        cy;
    logic [15:0] rr;
    int          s;
    int          c;
    for (int i = 0; i < 4; i++)
      if (bcd && (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9)) inv = 1'b1;
    if (!bcd) begin
      s  = sub ? int'(av) - int'(bv) - int'(cin) : int'(av) + int'(bv) + int'(cin);
      cy = (s < 0) || (s > 65535);
      rr = 16'(s);
    end else if (!inv) begin
      s  = sub ? bcd_to_int(av) - bcd_to_int(bv) - int'(cin)
               : bcd_to_int(av) + bcd_to_int(bv) + int'(cin);
      cy = (s < 0) || (s > 9999);
      if (s < 0) s += 10000;
      rr = int_to_bcd(s % 10000);
    end else begin
      c = int'(cin);
      rr = '0;
      for (int i = 0; i < 4; i++) begin
        int ad = int'(av[4*i +: 4]);
        int bd = int'(bv[4*i +: 4]);
        int t;
        if (!sub) begin
          t = ad + bd + c;
          if (t > 9) begin rr[4*i +: 4] = 4'(t + 6); c = 1; end
          else       begin rr[4*i +: 4] = 4'(t);     c = 0; end
        end else begin
          t = ad - bd - c;
          if (t < 0) begin rr[4*i +: 4] = 4'(t + 10); c = 1; end
          else       begin rr[4*i +: 4] = 4'(t);      c = 0; end
        end
      end
      cy = (c != 0);
    end
    return {inv, 1'b0, cy, (rr == 16'h0000), rr};
  endfunction

  // Caller is at a negedge; leaves the bench at the negedge of the done cycle
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sub,
                        input logic bcd, input logic cin, input string tag);
    logic [19:0] exp = model(av, bv, sub, bcd, cin);
    start = 1'b1; a = av; b = bv; add_sub = sub; bcd_mode = bcd; carry_in = cin;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    add_sub = 1'($urandom); bcd_mode = 1'($urandom); carry_in = 1'($urandom);
    for (int c = 1; c <= DIGITS; c++) begin
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(1));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(0));
      check($sformatf("%s r held c%0d", tag, c), 32'(r), 32'(prev_r));
      check($sformatf("%s flags held c%0d", tag, c), 32'(flags), 32'(prev_flags));
      @(negedge clk);
    end
    check($sformatf("%s done", tag), 32'(done), 32'(1));
    check($sformatf("%s busy end", tag), 32'(busy), 32'(0));
    check($sformatf("%s r", tag), 32'(r), 32'(exp[15:0]));
    check($sformatf("%s flags", tag), 32'(flags), 32'(exp[19:16]));
    prev_r = exp[15:0];
    prev_flags = exp[19:16];
    $display("op %s: a=%h b=%h sub=%0d bcd=%0d cin=%0d -> r=%h flags=%b", tag, av, bv, sub, bcd, cin, r, flags);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle done", 32'(done), 32'(0));
      check("idle busy", 32'(busy), 32'(0));
      check("idle r", 32'(r), 32'(prev_r));
      check("idle flags", 32'(flags), 32'(prev_flags));
    end
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(9, 0));
    return v;
  endfunction

  initial begin
    reset_n = 1'b1; start = 1'b0; add_sub = 1'b0; bcd_mode = 1'b0;
    a = '0; b = '0; carry_in = 1'b0;
    prev_r = '0; prev_flags = '0;
    #2 reset_n = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset r", 32'(r), 32'(0));
    check("reset flags", 32'(flags), 32'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Directed cases with constants taken straight from the expected arithmetic
    run_op(16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, "bcd_add_1234_5678");
    check("k 6912 r", 32'(r), 32'h6912);  check("k 6912 f", 32'(flags), 32'b0000);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b1, 1'b0, "bcd_add_9999_0001");
    check("k 0000 r", 32'(r), 32'h0000);  check("k 0000 f", 32'(flags), 32'b0011);
    run_op(16'h0100, 16'h0001, 1'b1, 1'b1, 1'b0, "bcd_sub_0100_0001");
    check("k 0099 r", 32'(r), 32'h0099);  check("k 0099 f", 32'(flags), 32'b0000);
    run_op(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, "bcd_sub_0000_0001");
    check("k 9999 r", 32'(r), 32'h9999);  check("k 9999 f", 32'(flags), 32'b0010);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "bin_add_ffff_0001");
    check("k bin r", 32'(r), 32'h0000);   check("k bin f", 32'(flags), 32'b0011);
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b0, "bin_add_00a0");
    check("k bin a0 r", 32'(r), 32'h00A0); check("k bin a0 f", 32'(flags), 32'b0000);
    idle(1);
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b1, 1'b0, "bcd_add_00a0");
    check("k bcd a0 r", 32'(r), 32'h0100); check("k bcd a0 f", 32'(flags), 32'b1000);

    // Start during RUN is ignored
    start = 1'b1; a = 16'h1234; b = 16'h5678; add_sub = 1'b0; bcd_mode = 1'b1; carry_in = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 16'h9999; b = 16'h9999; add_sub = 1'b1; carry_in = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ign busy c3", 32'(busy), 32'(1));
    @(negedge clk);
    check("ign busy c4", 32'(busy), 32'(1));
    @(negedge clk);
    check("ign done", 32'(done), 32'(1));
    check("ign r", 32'(r), 32'h6912);
    check("ign flags", 32'(flags), 32'b0000);
    prev_r = 16'h6912; prev_flags = 4'b0000;
    $display("op ignore_start: r=%h flags=%b", r, flags);
    idle(2);

    // Reset asserted in cycle 2 of RUN aborts without a done pulse
    start = 1'b1; a = 16'h4321; b = 16'h1111; add_sub = 1'b0; bcd_mode = 1'b1; carry_in = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst r", 32'(r), 32'(0));
    check("rst flags", 32'(flags), 32'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst hold done", 32'(done), 32'(0));
    end
    reset_n = 1'b1;
    prev_r = '0; prev_flags = '0;
    $display("op reset_mid_run: busy=%0d r=%h flags=%b", busy, r, flags);
    idle(6);

    // Randomized operations
    for (int n = 0; n < 150; n++) begin
      logic        bcd = 1'($urandom);
      logic [15:0] av;
      logic [15:0] bv;
      if (bcd && ($urandom_range(9, 0) < 8)) begin
        av = rand_bcd(); bv = rand_bcd();
      end else begin
        av = 16'($urandom); bv = 16'($urandom);
      end
      run_op(av, bv, 1'($urandom), bcd, 1'($urandom), $sformatf("rand%0d", n));
      idle($urandom_range(2, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
